// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, special registers,
// and the write-back source encoding.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2
  } wb_src_e;

  // Link writes take priority over the load/ALU choice.
  function automatic wb_src_e wb_src_sel(
    input logic link,
    input logic mem_to_reg
  );
    if (link)
      return WB_SRC_LINK;
    else if (mem_to_reg)
      return WB_SRC_MEM;
    else
      return WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Architectural register storage: one write port, two
// combinational read ports, r0 hard-wired to zero.
module reg_file_2r1w
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= RESET_VAL;
    end else if (we && waddr != R0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == R0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == R0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/writeback_regfile.sv
// MIPS write-back stage: MEM/WB capture, result select, register
// file commit with read bypass, EX forwarding and retire counting.
module writeback_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid_i,
  input  logic              wb_reg_write_i,
  input  logic              wb_mem_to_reg_i,
  input  logic              wb_link_i,
  input  logic [ADDR_W-1:0] wb_dest_i,
  input  logic [DATA_W-1:0] wb_alu_result_i,
  input  logic [DATA_W-1:0] wb_mem_data_i,
  input  logic [DATA_W-1:0] wb_pc_plus8_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              fwd_valid_o,
  output logic [ADDR_W-1:0] fwd_dest_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [31:0]       retire_cnt_o
);

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] RA = ADDR_W'(REG_RA);

  logic              st_valid;
  logic              st_rw;
  logic              st_written;
  logic [ADDR_W-1:0] st_dest;
  logic [DATA_W-1:0] st_data;

  logic [31:0]       retire_cnt;

  wb_src_e           src;
  logic [ADDR_W-1:0] cap_dest;
  logic [DATA_W-1:0] cap_data;
  logic              we;
  logic              commit;
  logic              retire;
  logic [DATA_W-1:0] rf_rs;
  logic [DATA_W-1:0] rf_rt;

  assign src = wb_src_sel(wb_link_i, wb_mem_to_reg_i);

  always_comb begin
    cap_dest = wb_dest_i;
    cap_data = wb_alu_result_i;
    unique case (src)
      WB_SRC_LINK: begin
        cap_dest = RA;
        cap_data = wb_pc_plus8_i;
      end
      WB_SRC_MEM: cap_data = wb_mem_data_i;
      default: ;
    endcase
  end

  assign we = st_valid & st_rw & ~st_written
            & (st_dest != R0);
  assign commit = we & ~flush_i;
  assign retire = st_valid & ~stall_i & ~flush_i;

  // A stalled instruction commits once, then only waits to retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid   <= 1'b0;
      st_rw      <= 1'b0;
      st_written <= 1'b0;
      st_dest    <= '0;
      st_data    <= '0;
    end else if (flush_i) begin
      st_valid <= 1'b0;
    end else if (stall_i) begin
      if (we)
        st_written <= 1'b1;
    end else begin
      st_valid   <= wb_valid_i;
      st_rw      <= wb_reg_write_i;
      st_written <= 1'b0;
      st_dest    <= cap_dest;
      st_data    <= cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt <= '0;
    else if (retire)
      retire_cnt <= retire_cnt + 32'd1;
  end

  reg_file_2r1w #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RESET_VAL (RESET_VAL)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit),
    .waddr   (st_dest),
    .wdata   (st_data),
    .raddr_a (rs_addr_i),
    .raddr_b (rt_addr_i),
    .rdata_a (rf_rs),
    .rdata_b (rf_rt)
  );

  assign rs_data_o = (we && rs_addr_i == st_dest)
                   ? st_data : rf_rs;
  assign rt_data_o = (we && rt_addr_i == st_dest)
                   ? st_data : rf_rt;

  assign fwd_valid_o  = we;
  assign fwd_dest_o   = st_valid ? st_dest : '0;
  assign fwd_data_o   = st_valid ? st_data : '0;
  assign retire_cnt_o = retire_cnt;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        wb_link;
  logic [4:0]  wb_dest;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_pc_plus8;
  logic        stall;
  logic        flush;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_regfile dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_valid_i      (wb_valid),
    .wb_reg_write_i  (wb_reg_write),
    .wb_mem_to_reg_i (wb_mem_to_reg),
    .wb_link_i       (wb_link),
    .wb_dest_i       (wb_dest),
    .wb_alu_result_i (wb_alu_result),
    .wb_mem_data_i   (wb_mem_data),
    .wb_pc_plus8_i   (wb_pc_plus8),
    .stall_i         (stall),
    .flush_i         (flush),
    .rs_addr_i       (rs_addr),
    .rt_addr_i       (rt_addr),
    .rs_data_o       (rs_data),
    .rt_data_o       (rt_data),
    .fwd_valid_o     (fwd_valid),
    .fwd_dest_o      (fwd_dest),
    .fwd_data_o      (fwd_data),
    .retire_cnt_o    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural file, one pending result, count.
  logic [31:0] mregs [32];
  logic        p_valid;
  logic        p_rw;
  logic        p_done;
  logic [4:0]  p_dest;
  logic [31:0] p_data;
  logic [31:0] m_cnt;

  function automatic logic m_pend();
    return p_valid && p_rw && !p_done && p_dest != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_pend() && a == p_dest) return p_data;
    return mregs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    p_valid = 0; p_rw = 0; p_done = 0;
    p_dest = 0; p_data = 0; m_cnt = 0;
  endtask

  // Advance one clock; model follows the inputs seen at the edge.
  task automatic tick();
    logic pend;
    @(posedge clk);
    pend = m_pend();
    if (pend && !flush) mregs[p_dest] = p_data;
    if (p_valid && !stall && !flush) m_cnt = m_cnt + 1;
    if (flush) p_valid = 0;
    else if (stall) begin
      if (pend) p_done = 1;
    end else begin
      p_valid = wb_valid;
      p_rw = wb_reg_write;
      p_done = 0;
      if (wb_link) begin
        p_dest = 5'd31;
        p_data = wb_pc_plus8;
      end else begin
        p_dest = wb_dest;
        p_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
      end
    end
    #1;
  endtask

  task automatic present(
    input logic v, rw, m2r, lnk,
    input logic [4:0] d,
    input logic [31:0] alu, mem, pc8
  );
    wb_valid = v; wb_reg_write = rw;
    wb_mem_to_reg = m2r; wb_link = lnk;
    wb_dest = d; wb_alu_result = alu;
    wb_mem_data = mem; wb_pc_plus8 = pc8;
    stall = 0; flush = 0;
  endtask

  task automatic idle();
    present(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    rs_addr = 0; rt_addr = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(32 - i);
      #1;
      n_cmp++;
      if (rs_data !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_rs r%0d: got %h want 0", i, rs_data);
      end
      n_cmp++;
      if (rt_data !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_rt r%0d: got %h want 0", 32 - i, rt_data);
      end
    end
    n_cmp++;
    if (retire_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %h want 0", retire_cnt);
    end
    n_cmp++;
    if (fwd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_fwd: got %b want 0", fwd_valid);
    end
  endtask

  task automatic test_alu_bypass();
    logic [31:0] c0;
    c0 = m_cnt;
    present(1, 1, 0, 0, 5'd5, 32'h12345678, 32'h0, 32'h0);
    tick();
    idle();
    rs_addr = 5;
    #1;
    n_cmp++;
    if (rs_data !== 32'h12345678) begin
      n_bad++;
      $display("FAIL alu_bypass: got %h want 12345678", rs_data);
    end
    n_cmp++;
    if (fwd_valid !== 1'b1 || fwd_dest !== 5'd5) begin
      n_bad++;
      $display("FAIL alu_fwd: got %b/%0d want 1/5", fwd_valid, fwd_dest);
    end
    tick();
    tick();
    n_cmp++;
    if (rs_data !== 32'h12345678) begin
      n_bad++;
      $display("FAIL alu_file: got %h want 12345678", rs_data);
    end
    n_cmp++;
    if (retire_cnt !== c0 + 32'd1) begin
      n_bad++;
      $display("FAIL alu_cnt: got %h want %h", retire_cnt, c0 + 1);
    end
  endtask

  task automatic test_load_r0();
    logic [31:0] c0;
    c0 = m_cnt;
    present(1, 1, 1, 0, 5'd7, 32'h1, 32'hDEADBEEF, 32'h0);
    tick();
    present(1, 1, 0, 0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
    rs_addr = 7;
    #1;
    n_cmp++;
    if (rs_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL load_bypass: got %h want deadbeef", rs_data);
    end
    tick();
    idle();
    rs_addr = 0; rt_addr = 7;
    #1;
    n_cmp++;
    if (rs_data !== 32'd0) begin
      n_bad++;
      $display("FAIL r0_read: got %h want 0", rs_data);
    end
    n_cmp++;
    if (fwd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_fwd: got %b want 0", fwd_valid);
    end
    n_cmp++;
    if (rt_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL load_file: got %h want deadbeef", rt_data);
    end
    tick();
    n_cmp++;
    if (retire_cnt !== c0 + 32'd2) begin
      n_bad++;
      $display("FAIL r0_cnt: got %h want %h", retire_cnt, c0 + 2);
    end
  endtask

  task automatic test_link();
    logic [31:0] r3;
    r3 = mregs[3];
    present(1, 1, 0, 1, 5'd3, 32'h77, 32'h88, 32'h00400010);
    tick();
    idle();
    tick();
    rs_addr = 31; rt_addr = 3;
    #1;
    n_cmp++;
    if (rs_data !== 32'h00400010) begin
      n_bad++;
      $display("FAIL link_r31: got %h want 00400010", rs_data);
    end
    n_cmp++;
    if (rt_data !== r3) begin
      n_bad++;
      $display("FAIL link_r3: got %h want %h", rt_data, r3);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] c0;
    logic [31:0] r9;
    c0 = m_cnt;
    r9 = mregs[9];
    present(1, 1, 0, 0, 5'd9, 32'hA5A5A5A5, 32'h0, 32'h0);
    stall = 1; flush = 1;
    tick();
    idle();
    rs_addr = 9;
    #1;
    n_cmp++;
    if (fwd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_fwd: got %b want 0", fwd_valid);
    end
    tick();
    n_cmp++;
    if (rs_data !== r9) begin
      n_bad++;
      $display("FAIL flush_r9: got %h want %h", rs_data, r9);
    end
    n_cmp++;
    if (retire_cnt !== c0) begin
      n_bad++;
      $display("FAIL flush_cnt: got %h want %h", retire_cnt, c0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    c0 = m_cnt;
    present(1, 1, 0, 0, 5'd9, 32'h5A, 32'h0, 32'h0);
    tick();
    present(1, 1, 0, 0, 5'd9, 32'h99, 32'h0, 32'h0);
    stall = 1;
    rs_addr = 9;
    #1;
    n_cmp++;
    if (fwd_valid !== 1'b1 || rs_data !== 32'h5A) begin
      n_bad++;
      $display("FAIL stall_pend: got %b/%h want 1/5a", fwd_valid, rs_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (fwd_valid !== 1'b0 || rs_data !== 32'h5A) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got %b/%h want 0/5a", i, fwd_valid, rs_data);
      end
      n_cmp++;
      if (retire_cnt !== c0) begin
        n_bad++;
        $display("FAIL stall_cnt%0d: got %h want %h", i, retire_cnt, c0);
      end
    end
    idle();
    tick();
    n_cmp++;
    if (retire_cnt !== c0 + 32'd1 || rs_data !== 32'h5A) begin
      n_bad++;
      $display("FAIL stall_exit: got %h/%h want %h/5a", retire_cnt, rs_data, c0 + 1);
    end
  endtask

  task automatic test_wrap();
    force dut.retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 32'hFFFFFFFF;
    present(1, 0, 0, 0, 5'd2, 32'h3, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    n_cmp++;
    if (retire_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_cnt: got %h want 0", retire_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      present($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              5'($urandom), $urandom, $urandom, $urandom);
      stall = $urandom_range(0, 4) == 0;
      rs_addr = ($urandom_range(0, 2) == 0) ? p_dest : 5'($urandom);
      rt_addr = ($urandom_range(0, 2) == 0) ? p_dest : 5'($urandom);
      #1;
      n_cmp++;
      if (rs_data !== m_read(rs_addr) || rt_data !== m_read(rt_addr)) begin
        n_bad++;
        $display("FAIL rand_read%0d: got %h/%h want %h/%h", n,
                 rs_data, rt_data, m_read(rs_addr), m_read(rt_addr));
      end
      n_cmp++;
      if (fwd_valid !== m_pend()
          || fwd_dest !== (p_valid ? p_dest : 5'd0)
          || fwd_data !== (p_valid ? p_data : 32'd0)) begin
        n_bad++;
        $display("FAIL rand_fwd%0d: got %b/%0d/%h want %b/%0d/%h", n,
                 fwd_valid, fwd_dest, fwd_data, m_pend(),
                 p_valid ? p_dest : 5'd0, p_valid ? p_data : 32'd0);
      end
      n_cmp++;
      if (retire_cnt !== m_cnt) begin
        n_bad++;
        $display("FAIL rand_cnt%0d: got %h want %h", n, retire_cnt, m_cnt);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    present(1, 1, 0, 0, 5'd4, 32'hCAFEF00D, 32'h0, 32'h0);
    tick();
    idle();
    rs_addr = 4;
    #1;
    n_cmp++;
    if (rs_data !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL areset_pend: got %h want cafef00d", rs_data);
    end
    rst_n = 0;
    m_reset();
    #1;
    n_cmp++;
    if (rs_data !== 32'd0 || fwd_valid !== 1'b0 || retire_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL areset_now: got %h/%b/%h want 0/0/0", rs_data, fwd_valid, retire_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    tick();
    n_cmp++;
    if (rs_data !== 32'd0) begin
      n_bad++;
      $display("FAIL areset_r4: got %h want 0", rs_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu_bypass();
    test_load_r0();
    test_link();
    test_stall_flush();
    test_stall();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
